nemu_measure_controller: RTL and testbench

NEMU_MEASURE_CONTROLLER -- requirements
Module: nemu_measure_controller

---
 rtl/nemu_measure_controller.sv | 154 +++++++++++++++
 tb/tb_nemu_measure_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nemu_measure_controller.sv
// Run sequencer for a network emulator: warmup, measured injection and drain phases
// with saturating popcount packet counters and a run-time timestamp broadcast.
module nemu_measure_controller #(
  parameter int PORTS     = 16,
  parameter int TS_WIDTH  = 24,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_warmup_pkts,
  input  logic [CNT_WIDTH-1:0] i_measure_pkts,
  input  logic [TS_WIDTH-1:0]  i_drain_timeout,
  input  logic [PORTS-1:0]     i_inj_valid,
  input  logic [PORTS-1:0]     i_inj_measure,
  input  logic [PORTS-1:0]     i_rx_valid,
  input  logic [PORTS-1:0]     i_rx_measure,
  output logic [TS_WIDTH-1:0]  o_timestamp,
  output logic                 o_src_enable,
  output logic                 o_measure,
  output logic [2:0]           o_state,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_total_in,
  output logic [CNT_WIDTH-1:0] o_total_out,
  output logic [CNT_WIDTH-1:0] o_meas_in,
  output logic [CNT_WIDTH-1:0] o_meas_out
);

  // state     | meaning
  // S_IDLE    | waiting for i_start, sources off
  // S_WARMUP  | sources inject untagged packets until warmup count met
  // S_MEASURE | sources tag packets as measured until measure count met
  // S_DRAIN   | wait for measured packets to eject, bounded by drain timeout
  // S_DONE    | results held until i_start drops
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] tin_q, tin_d, tout_q, tout_d, min_q, min_d, mout_q, mout_d;
  logic [CNT_WIDTH-1:0] tin_nxt, tout_nxt, min_nxt, mout_nxt;
  logic [TS_WIDTH-1:0]  ts_q, ts_d, drain_q, drain_d, drain_nxt;
  logic                 timeout_q, timeout_d;
  logic                 running;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [PORTS-1:0] v);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < PORTS; i++) n = n + CNT_WIDTH'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign running   = (state_q == S_WARMUP) || (state_q == S_MEASURE) || (state_q == S_DRAIN);
  assign tin_nxt   = sat_add(tin_q,  popcnt(i_inj_valid));
  assign min_nxt   = sat_add(min_q,  popcnt(i_inj_valid & i_inj_measure));
  assign tout_nxt  = sat_add(tout_q, popcnt(i_rx_valid));
  assign mout_nxt  = sat_add(mout_q, popcnt(i_rx_valid & i_rx_measure));
  assign drain_nxt = (&drain_q) ? drain_q : drain_q + TS_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    tin_d     = tin_q;
    tout_d    = tout_q;
    min_d     = min_q;
    mout_d    = mout_q;
    ts_d      = ts_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;

    if (running) begin
      tin_d  = tin_nxt;
      tout_d = tout_nxt;
      min_d  = min_nxt;
      mout_d = mout_nxt;
      ts_d   = ts_q + TS_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_WARMUP;
          tin_d     = '0;
          tout_d    = '0;
          min_d     = '0;
          mout_d    = '0;
          ts_d      = '0;
          drain_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_WARMUP:  if (tin_nxt >= i_warmup_pkts)  state_d = S_MEASURE;
      S_MEASURE: if (min_nxt >= i_measure_pkts) state_d = S_DRAIN;
      S_DRAIN: begin
        drain_d = drain_nxt;
        // clean completion wins over a timeout landing in the same cycle
        if (mout_nxt >= min_nxt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (drain_nxt >= i_drain_timeout) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE:  if (!i_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tin_q     <= '0;
      tout_q    <= '0;
      min_q     <= '0;
      mout_q    <= '0;
      ts_q      <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tin_q     <= tin_d;
      tout_q    <= tout_d;
      min_q     <= min_d;
      mout_q    <= mout_d;
      ts_q      <= ts_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_state      = state_q;
  assign o_src_enable = running;
  assign o_measure    = (state_q == S_MEASURE);
  assign o_done       = (state_q == S_DONE);
  assign o_timeout    = timeout_q;
  assign o_timestamp  = ts_q;
  assign o_total_in   = tin_q;
  assign o_total_out  = tout_q;
  assign o_meas_in    = min_q;
  assign o_meas_out   = mout_q;

endmodule

// File: tb/tb_nemu_measure_controller.sv
// Randomized and directed bench for nemu_measure_controller against a cycle-level
// behavioural model of the run phases, counters and timestamp.
module tb_nemu_measure_controller;

  localparam int PORTS = 16;
  localparam int TSW   = 10;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int TSMOD = 1 << TSW;
  localparam int S_IDLE = 0, S_WARMUP = 1, S_MEASURE = 2, S_DRAIN = 3, S_DONE = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_start = 1'b0;
  logic [CW-1:0]    i_warmup_pkts = '0;
  logic [CW-1:0]    i_measure_pkts = '0;
  logic [TSW-1:0]   i_drain_timeout = '0;
  logic [PORTS-1:0] i_inj_valid = '0, i_inj_measure = '0, i_rx_valid = '0, i_rx_measure = '0;
  logic [TSW-1:0]   o_timestamp;
  logic             o_src_enable, o_measure, o_done, o_timeout;
  logic [2:0]       o_state;
  logic [CW-1:0]    o_total_in, o_total_out, o_meas_in, o_meas_out;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  int m_state = S_IDLE, m_tin = 0, m_tout = 0, m_min = 0, m_mout = 0, m_ts = 0, m_drain = 0;
  bit m_to = 1'b0;

  bit d1v, d1m, d2v, d2m;
  bit ts_wrapped;
  int prev_ts;

  always #5 clk = ~clk;

  nemu_measure_controller #(.PORTS(PORTS), .TS_WIDTH(TSW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_warmup_pkts(i_warmup_pkts), .i_measure_pkts(i_measure_pkts),
    .i_drain_timeout(i_drain_timeout),
    .i_inj_valid(i_inj_valid), .i_inj_measure(i_inj_measure),
    .i_rx_valid(i_rx_valid), .i_rx_measure(i_rx_measure),
    .o_timestamp(o_timestamp), .o_src_enable(o_src_enable), .o_measure(o_measure),
    .o_state(o_state), .o_done(o_done), .o_timeout(o_timeout),
    .o_total_in(o_total_in), .o_total_out(o_total_out),
    .o_meas_in(o_meas_in), .o_meas_out(o_meas_out)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_edge();
    int n_st, n_tin, n_tout, n_min, n_mout, n_ts, n_dr;
    bit n_to;
    if (!reset_n) begin
      m_state = S_IDLE; m_tin = 0; m_tout = 0; m_min = 0; m_mout = 0;
      m_ts = 0; m_drain = 0; m_to = 1'b0;
      return;
    end
    n_st = m_state; n_tin = m_tin; n_tout = m_tout; n_min = m_min; n_mout = m_mout;
    n_ts = m_ts; n_dr = m_drain; n_to = m_to;
    if (m_state == S_WARMUP || m_state == S_MEASURE || m_state == S_DRAIN) begin
      n_tin  = sat(m_tin  + $countones(i_inj_valid));
      n_min  = sat(m_min  + $countones(i_inj_valid & i_inj_measure));
      n_tout = sat(m_tout + $countones(i_rx_valid));
      n_mout = sat(m_mout + $countones(i_rx_valid & i_rx_measure));
      n_ts   = (m_ts + 1) % TSMOD;
    end
    case (m_state)
      S_IDLE: if (i_start) begin
        n_st = S_WARMUP; n_tin = 0; n_tout = 0; n_min = 0; n_mout = 0;
        n_ts = 0; n_dr = 0; n_to = 1'b0;
      end
      S_WARMUP:  if (n_tin >= int'(i_warmup_pkts)) n_st = S_MEASURE;
      S_MEASURE: if (n_min >= int'(i_measure_pkts)) n_st = S_DRAIN;
      S_DRAIN: begin
        n_dr = (m_drain < TSMOD - 1) ? m_drain + 1 : TSMOD - 1;
        if (n_mout >= n_min) begin
          n_st = S_DONE; n_to = 1'b0;
        end else if (n_dr >= int'(i_drain_timeout)) begin
          n_st = S_DONE; n_to = 1'b1;
        end
      end
      S_DONE:  if (!i_start) n_st = S_IDLE;
      default: n_st = S_IDLE;
    endcase
    m_state = n_st; m_tin = n_tin; m_tout = n_tout; m_min = n_min; m_mout = n_mout;
    m_ts = n_ts; m_drain = n_dr; m_to = n_to;
  endtask

  task automatic compare_all();
    bit run;
    run = (m_state == S_WARMUP || m_state == S_MEASURE || m_state == S_DRAIN);
    chk_eq("state",    32'(o_state),      32'(m_state));
    chk_eq("src_en",   32'(o_src_enable), 32'(run));
    chk_eq("measure",  32'(o_measure),    32'(m_state == S_MEASURE));
    chk_eq("done",     32'(o_done),       32'(m_state == S_DONE));
    chk_eq("timeout",  32'(o_timeout),    32'(m_to));
    chk_eq("tstamp",   32'(o_timestamp),  32'(m_ts));
    chk_eq("tot_in",   32'(o_total_in),   32'(m_tin));
    chk_eq("tot_out",  32'(o_total_out),  32'(m_tout));
    chk_eq("meas_in",  32'(o_meas_in),    32'(m_min));
    chk_eq("meas_out", 32'(o_meas_out),   32'(m_mout));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (prev_ts == TSMOD - 1 && int'(o_timestamp) == 0 && o_src_enable) ts_wrapped = 1'b1;
    prev_ts = int'(o_timestamp);
  endtask

  task automatic drive_traffic(input int mode);
    case (mode)
      1, 2: begin
        i_inj_valid   = PORTS'(o_src_enable);
        i_inj_measure = PORTS'(o_src_enable & o_measure);
        i_rx_valid    = (mode == 1) ? PORTS'(d2v) : '0;
        i_rx_measure  = (mode == 1) ? PORTS'(d2m) : '0;
        d2v = d1v; d2m = d1m;
        d1v = o_src_enable; d1m = o_src_enable & o_measure;
      end
      3: begin
        i_inj_valid   = '1;
        i_inj_measure = o_measure ? '1 : '0;
        i_rx_valid    = '1;
        i_rx_measure  = '0;
      end
      4: begin
        i_inj_valid   = PORTS'($urandom) & PORTS'($urandom);
        i_inj_measure = o_measure ? PORTS'($urandom) : '0;
        i_rx_valid    = PORTS'($urandom) & PORTS'($urandom);
        i_rx_measure  = PORTS'($urandom);
        reset_n       = ($urandom_range(0, 149) != 0);
        if (m_state == S_IDLE || m_state == S_DONE) i_start = 1'b1;
        else i_start = ($urandom_range(0, 3) != 0);
      end
      default: begin
        i_inj_valid = '0; i_inj_measure = '0; i_rx_valid = '0; i_rx_measure = '0;
      end
    endcase
  endtask

  task automatic run_to_done(input int budget, input int mode,
                             output int cw, output int cm, output int cd);
    bit fin;
    cw = 0; cm = 0; cd = 0; fin = 1'b0;
    d1v = 0; d1m = 0; d2v = 0; d2m = 0;
    for (int n = 0; n < budget && !fin; n++) begin
      drive_traffic(mode);
      step();
      case (int'(o_state))
        S_WARMUP:  cw++;
        S_MEASURE: cm++;
        S_DRAIN:   cd++;
        default: ;
      endcase
      if (m_state == S_DONE) fin = 1'b1;
    end
    chk_eq("run_reached_done", 32'(fin), 32'd1);
  endtask

  task automatic end_run();
    reset_n = 1'b1;
    i_start = 1'b0;
    drive_traffic(0);
    step();
    chk_eq("back_to_idle", 32'(o_state), S_IDLE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cw, cm, cd;
    prev_ts = 0; ts_wrapped = 1'b0;

    reset_n = 1'b0;
    step();
    step();
    chk_eq("rst_state", 32'(o_state), S_IDLE);
    chk_eq("rst_tot_in", 32'(o_total_in), 0);
    reset_n = 1'b1;

    // warmup 4 / measure 4, one port, rx echo 2 cycles later
    i_warmup_pkts = 4; i_measure_pkts = 4; i_drain_timeout = 100; i_start = 1'b1;
    run_to_done(60, 1, cw, cm, cd);
    chk_eq("echo_warmup_cycles", 32'(cw), 4);
    chk_eq("echo_measure_cycles", 32'(cm), 4);
    chk_eq("echo_meas_in", 32'(o_meas_in), 4);
    chk_eq("echo_meas_out", 32'(o_meas_out), 4);
    chk_eq("echo_timeout", 32'(o_timeout), 0);
    i_start = 1'b1;
    step();
    chk_eq("done_holds", 32'(o_state), S_DONE);
    end_run();

    // all ports inject at once, then reset in MEASURE and restart
    i_warmup_pkts = 10; i_measure_pkts = 50; i_start = 1'b1;
    drive_traffic(0);
    step();
    chk_eq("burst_warmup", 32'(o_state), S_WARMUP);
    i_inj_valid = '1;
    step();
    chk_eq("burst_tot_in", 32'(o_total_in), 16);
    chk_eq("burst_state", 32'(o_state), S_MEASURE);
    i_inj_valid = '0;
    step();
    step();
    reset_n = 1'b0;
    step();
    chk_eq("midrst_state", 32'(o_state), S_IDLE);
    chk_eq("midrst_tot_in", 32'(o_total_in), 0);
    chk_eq("midrst_src_en", 32'(o_src_enable), 0);
    reset_n = 1'b1;
    step();
    chk_eq("rst_release_warmup", 32'(o_state), S_WARMUP);
    reset_n = 1'b0; i_start = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // measured packets never eject: drain timeout
    i_warmup_pkts = 2; i_measure_pkts = 2; i_drain_timeout = 5; i_start = 1'b1;
    run_to_done(60, 2, cw, cm, cd);
    chk_eq("to_drain_cycles", 32'(cd), 5);
    chk_eq("to_timeout", 32'(o_timeout), 1);
    end_run();

    // zero warmup, zero measure, no traffic
    i_warmup_pkts = 0; i_measure_pkts = 0; i_drain_timeout = 7; i_start = 1'b1;
    run_to_done(20, 0, cw, cm, cd);
    chk_eq("zero_w", 32'(cw), 1);
    chk_eq("zero_m", 32'(cm), 1);
    chk_eq("zero_d", 32'(cd), 1);
    chk_eq("zero_timeout", 32'(o_timeout), 0);
    end_run();

    // long run: timestamp wraps, counters saturate
    i_warmup_pkts = 1; i_measure_pkts = 1; i_drain_timeout = TSW'(TSMOD - 1); i_start = 1'b1;
    ts_wrapped = 1'b0;
    run_to_done(1200, 3, cw, cm, cd);
    chk_eq("ts_wrapped", 32'(ts_wrapped), 1);
    chk_eq("sat_tot_in", 32'(o_total_in), CMAX);
    chk_eq("sat_tot_out", 32'(o_total_out), CMAX);
    chk_eq("long_timeout", 32'(o_timeout), 1);
    end_run();

    for (int r = 0; r < 40; r++) begin
      i_warmup_pkts   = CW'($urandom_range(0, 40));
      i_measure_pkts  = CW'($urandom_range(0, 40));
      i_drain_timeout = TSW'($urandom_range(0, 30));
      i_start = 1'b1;
      run_to_done(400, 4, cw, cm, cd);
      end_run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
